// File: rtl/bcd_scan_display.sv
// Snapshots packed BCD digits on load and scans them onto a shared 7-segment bus.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame,
    output logic                  err
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] snap;
    logic [DW-1:0]       div;
    logic [IW-1:0]       idx;
    logic                tick;
    logic                last;
    logic                bad_in;
    logic                blank;
    logic [3:0]          nib;
    logic [6:0]          seg_nxt;
    logic [DIGITS-1:0]   an_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign tick = (div == DW'(SCAN_DIV - 1));
    assign last = (idx == IW'(DIGITS - 1));
    assign nib  = snap[4*int'(idx) +: 4];

    always_comb begin
        bad_in = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_in[4*k +: 4] > 4'd9) bad_in = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[k]: nibbles k..DIGITS-1 are all zero (invalid nibbles are nonzero)
    logic [DIGITS:0] upper_zero;
    always_comb begin
        upper_zero         = '0;
        upper_zero[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (snap[4*k +: 4] == 4'd0);
        end
        blank = (idx != '0) && upper_zero[idx];
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_nxt = decode(nib);
        an_nxt  = DIGITS'(1) << idx;
        if (blank) begin
            seg_nxt = '0;
            an_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            snap  <= '0;
            div   <= '0;
            idx   <= '0;
            err   <= 1'b0;
            seg   <= '0;
            an    <= '0;
            frame <= 1'b0;
        end else begin
            div <= tick ? '0 : div + DW'(1);
            if (tick) idx <= last ? '0 : idx + IW'(1);
            frame <= tick && last;
            if (load) snap <= bcd_in;
            if (load && bad_in) err <= 1'b1;
            // outputs come from pre-edge idx/snap, giving the 1-cycle display latency
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized bench for bcd_scan_display (DIGITS=4, SCAN_DIV=4) against a cycle-count model.
// Build with LEADING_ZERO_BLANK_EN defined to exercise the blanking model as well.
module tb_bcd_scan_display;

    localparam int D = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [4*D-1:0] bcd_in = '0;
    logic          load = 1'b0;
    logic [6:0]    seg;
    logic [D-1:0]  an;
    logic          frame;
    logic          err;

    int checks = 0;
    int errors = 0;

    // model state: edges since reset release, snapshot, sticky error
    int            mc = 0;
    logic [4*D-1:0] msnap = '0;
    logic          merr = 1'b0;
    logic [6:0]    eseg = '0;
    logic [D-1:0]  ean = '0;
    logic          efr = 1'b0;

    bcd_scan_display #(.DIGITS(D), .SCAN_DIV(S)) dut (
        .clk(clk), .clr(clr), .bcd_in(bcd_in), .load(load),
        .seg(seg), .an(an), .frame(frame), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [0:9];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d <= 9) ? tbl[d] : 7'h40;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, mc);
        end
    endtask

    task automatic step(input logic c, input logic ld, input logic [4*D-1:0] v);
        int  di;
        int  nv;
        bit  bad;
        clr    = c;
        load   = ld;
        bcd_in = v;
        @(posedge clk);
        if (c) begin
            mc = 0; msnap = '0; merr = 1'b0;
            eseg = '0; ean = '0; efr = 1'b0;
        end else begin
            di   = (mc / S) % D;
            nv   = int'((msnap >> (4*di)) & 16'hF);
            eseg = seg_of(nv);
            ean  = D'(1) << di;
`ifdef LEADING_ZERO_BLANK_EN
            if (di > 0 && (msnap >> (4*di)) == 0) begin
                eseg = '0;
                ean  = '0;
            end
`endif
            efr = ((mc % (S*D)) == S*D - 1);
            mc++;
            if (ld) begin
                msnap = v;
                bad = 1'b0;
                for (int k = 0; k < D; k++) if (((v >> (4*k)) & 16'hF) > 9) bad = 1'b1;
                if (bad) merr = 1'b1;
            end
        end
        #1;
        chk("seg", 32'(seg), 32'(eseg));
        chk("an", 32'(an), 32'(ean));
        chk("frame", 32'(frame), 32'(efr));
        chk("err", 32'(err), 32'(merr));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [4*D-1:0] rv;
        logic           rc;
        logic           rl;
        // reset and post-reset display of zero
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        run(6);
        // full scans of a valid value
        step(1'b0, 1'b1, 16'h1985);
        run(40);
        // invalid nibble sets sticky err; a later valid load keeps it
        step(1'b0, 1'b1, 16'h0A00);
        run(20);
        step(1'b0, 1'b1, 16'h0000);
        run(20);
        step(1'b0, 1'b1, 16'h0007);
        run(20);
        // clear mid-period, then restart
        step(1'b1, 1'b0, '0);
        run(9);
        step(1'b0, 1'b1, 16'h4321);
        run(10);
        // load coinciding with the tick edge into digit 1 (model covers this case)
        step(1'b1, 1'b0, '0);
        run(3);
        step(1'b0, 1'b1, 16'h4321);
        run(8);
        // randomized traffic: sparse clears, frequent loads, many zero digits
        for (int i = 0; i < 3000; i++) begin
            rc = ($urandom_range(0, 149) == 0);
            rl = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < D; k++) begin
                case ($urandom_range(0, 15))
                    0:              rv[4*k +: 4] = 4'($urandom_range(10, 15));
                    1, 2, 3, 4, 5:  rv[4*k +: 4] = 4'd0;
                    default:        rv[4*k +: 4] = 4'($urandom_range(0, 9));
                endcase
            end
            step(rc, rl, rv);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
